// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter
//   Shares one SRAM-like master port between the instruction-fetch port and
//   the data-memory port. One transaction is outstanding at a time. Each
//   response is routed back to the port that issued the request. An
//   in-flight fetch can be cancelled, and its response is then swallowed.
//
// Ports
//   clock, reset          : clock and synchronous active-high reset
//   inst_req/addr/cancel  : fetch request in (reads a word); cancel discards
//                           the response of the current fetch
//   inst_addr_ok/data_ok  : fetch accepted / fetch data valid (inst_rdata)
//   data_req/wr/size/addr/wdata : data request in
//   data_addr_ok/data_ok  : data accepted / read data valid or write done
//   m_*                   : shared SRAM-like master port toward the bridge
//
// Parameters
//   ARB_MODE        : 0 = data always wins a tie, 1 = round-robin
//   RESET_LAST_INST : round-robin history after reset (1 = inst went last)
module sram_like_arbiter #(
   parameter int ARB_MODE        = 0,
   parameter bit RESET_LAST_INST = 1'b1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        inst_req,
   input  logic [31:0] inst_addr,
   input  logic        inst_cancel,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   output logic        m_req,
   output logic        m_wr,
   output logic [1:0]  m_size,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   input  logic        m_addr_ok,
   input  logic        m_data_ok,
   input  logic [31:0] m_rdata
);

   typedef enum logic [2:0] {
      IDLE, INST_ADDR, DATA_ADDR, INST_WAIT, DATA_WAIT
   } state_t;

   state_t      state;
   logic        last_inst;   // 1 = the previous grant went to inst
   logic        drop;        // current fetch response must be swallowed
   logic        wr_r;
   logic [1:0]  size_r;
   logic [31:0] addr_r;
   logic [31:0] wdata_r;

   logic        idle;
   logic        pick_data;
   logic        grant_inst;
   logic        grant_data;

   // Data wins when it asks alone, in fixed-priority mode, or when inst
   // held the last grant in round-robin mode.
   always_comb begin
      idle       = (state == IDLE) && !reset;
      pick_data  = data_req && (!inst_req || (ARB_MODE == 0) || last_inst);
      grant_data = idle && pick_data;
      grant_inst = idle && inst_req && !pick_data;
   end

   assign inst_addr_ok = grant_inst;
   assign data_addr_ok = grant_data;

   // A cancel arriving in the same cycle as the response also discards it.
   assign inst_data_ok = !reset && (state == INST_WAIT) && m_data_ok
                         && !drop && !inst_cancel;
   assign data_data_ok = !reset && (state == DATA_WAIT) && m_data_ok;

   assign inst_rdata = m_rdata;
   assign data_rdata = m_rdata;

   // The master port only ever sees the latched copy of the request.
   assign m_wr    = wr_r;
   assign m_size  = size_r;
   assign m_addr  = addr_r;
   assign m_wdata = wdata_r;

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         drop      <= 1'b0;
         last_inst <= RESET_LAST_INST;
         m_req     <= 1'b0;
         wr_r      <= 1'b0;
         size_r    <= 2'd0;
         addr_r    <= '0;
         wdata_r   <= '0;
      end else begin
         case (state)
            IDLE: begin
               drop <= 1'b0;
               if (grant_data) begin
                  wr_r      <= data_wr;
                  size_r    <= data_size;
                  addr_r    <= data_addr;
                  wdata_r   <= data_wdata;
                  last_inst <= 1'b0;
                  m_req     <= 1'b1;
                  state     <= DATA_ADDR;
               end else if (grant_inst) begin
                  wr_r      <= 1'b0;
                  size_r    <= 2'd2;
                  addr_r    <= inst_addr;
                  wdata_r   <= '0;
                  last_inst <= 1'b1;
                  drop      <= inst_cancel;
                  m_req     <= 1'b1;
                  state     <= INST_ADDR;
               end
            end
            INST_ADDR: begin
               // m_req stays up even after a cancel; the response is dropped.
               if (inst_cancel) drop <= 1'b1;
               if (m_addr_ok) begin
                  m_req <= 1'b0;
                  state <= INST_WAIT;
               end
            end
            DATA_ADDR: begin
               if (m_addr_ok) begin
                  m_req <= 1'b0;
                  state <= DATA_WAIT;
               end
            end
            INST_WAIT: begin
               if (inst_cancel) drop <= 1'b1;
               if (m_data_ok) begin
                  drop  <= 1'b0;
                  state <= IDLE;
               end
            end
            DATA_WAIT: begin
               if (m_data_ok) state <= IDLE;
            end
            default: begin
               m_req <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Bench for sram_like_arbiter. Instance g_dut[0] uses fixed priority and
// instance g_dut[1] uses round-robin. Each instance has its own stimulus.
// A transaction-level model tracks every instance and is compared on each
// falling edge. Directed scenarios add literal expectations.
module tb_sram_like_arbiter;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   logic [1:0]  inst_req, inst_cancel, data_req, data_wr, m_addr_ok, m_data_ok;
   logic [31:0] inst_addr [2];
   logic [31:0] data_addr [2];
   logic [31:0] data_wdata [2];
   logic [31:0] m_rdata [2];
   logic [1:0]  data_size [2];

   wire  [1:0]  inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, m_req, m_wr;
   wire  [31:0] inst_rdata [2];
   wire  [31:0] data_rdata [2];
   wire  [31:0] m_addr [2];
   wire  [31:0] m_wdata [2];
   wire  [1:0]  m_size [2];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      sram_like_arbiter #(.ARB_MODE(g), .RESET_LAST_INST(1'b1)) dut (
         .clock(clock), .reset(reset),
         .inst_req(inst_req[g]), .inst_addr(inst_addr[g]), .inst_cancel(inst_cancel[g]),
         .inst_addr_ok(inst_addr_ok[g]), .inst_data_ok(inst_data_ok[g]),
         .inst_rdata(inst_rdata[g]),
         .data_req(data_req[g]), .data_wr(data_wr[g]), .data_size(data_size[g]),
         .data_addr(data_addr[g]), .data_wdata(data_wdata[g]),
         .data_addr_ok(data_addr_ok[g]), .data_data_ok(data_data_ok[g]),
         .data_rdata(data_rdata[g]),
         .m_req(m_req[g]), .m_wr(m_wr[g]), .m_size(m_size[g]), .m_addr(m_addr[g]),
         .m_wdata(m_wdata[g]), .m_addr_ok(m_addr_ok[g]), .m_data_ok(m_data_ok[g]),
         .m_rdata(m_rdata[g])
      );
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic cmp(input string nm, input int k, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s dut%0d at %0t: got %h, expected %h", nm, k, $time, act, exp);
      end
   endtask

   // ---------------- transaction-level model ----------------
   // owner: 0 = no transaction, 1 = fetch, 2 = data access
   int          owner [2];
   bit          issued [2];   // master has taken the address
   bit          dropped [2];
   bit          last_i [2];
   bit          t_wr [2];
   logic [1:0]  t_size [2];
   logic [31:0] t_addr [2];
   logic [31:0] t_wdata [2];
   bit          mvalid = 1'b0;

   // Instance k runs ARB_MODE = k.
   function automatic bit win_data(input int k);
      return data_req[k] && (!inst_req[k] || k == 0 || last_i[k]);
   endfunction

   always @(posedge clock) begin
      if (reset) begin
         mvalid = 1'b1;
         for (int k = 0; k < 2; k++) begin
            owner[k] = 0; issued[k] = 0; dropped[k] = 0; last_i[k] = 1;
            t_wr[k] = 0; t_size[k] = 0; t_addr[k] = 0; t_wdata[k] = 0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (owner[k] == 0) begin
               if (data_req[k] || inst_req[k]) begin
                  issued[k] = 0;
                  if (win_data(k)) begin
                     owner[k] = 2; last_i[k] = 0; dropped[k] = 0;
                     t_wr[k] = data_wr[k]; t_size[k] = data_size[k];
                     t_addr[k] = data_addr[k]; t_wdata[k] = data_wdata[k];
                  end else begin
                     owner[k] = 1; last_i[k] = 1; dropped[k] = inst_cancel[k];
                     t_wr[k] = 0; t_size[k] = 2; t_addr[k] = inst_addr[k]; t_wdata[k] = 0;
                  end
               end
            end else begin
               if (owner[k] == 1 && inst_cancel[k]) dropped[k] = 1;
               if (!issued[k]) begin
                  if (m_addr_ok[k]) issued[k] = 1;
               end else if (m_data_ok[k]) begin
                  owner[k] = 0; dropped[k] = 0;
               end
            end
         end
      end
   end

   always @(negedge clock) begin
      if (mvalid) begin
         for (int k = 0; k < 2; k++) begin
            bit busy, e_iaok, e_daok, e_mreq, e_idok, e_ddok;
            busy   = (owner[k] != 0);
            e_iaok = !reset && !busy && inst_req[k] && !win_data(k);
            e_daok = !reset && !busy && win_data(k);
            e_mreq = busy && !issued[k];
            e_idok = !reset && owner[k] == 1 && issued[k] && m_data_ok[k]
                     && !dropped[k] && !inst_cancel[k];
            e_ddok = !reset && owner[k] == 2 && issued[k] && m_data_ok[k];
            cmp("model inst_addr_ok", k, inst_addr_ok[k], e_iaok);
            cmp("model data_addr_ok", k, data_addr_ok[k], e_daok);
            cmp("model m_req", k, m_req[k], e_mreq);
            cmp("model inst_data_ok", k, inst_data_ok[k], e_idok);
            cmp("model data_data_ok", k, data_data_ok[k], e_ddok);
            if (e_mreq) begin
               cmp("model m_addr", k, m_addr[k], t_addr[k]);
               cmp("model m_wr", k, m_wr[k], t_wr[k]);
               cmp("model m_size", k, m_size[k], t_size[k]);
               cmp("model m_wdata", k, m_wdata[k], t_wdata[k]);
            end
            if (e_idok) cmp("model inst_rdata", k, inst_rdata[k], m_rdata[k]);
            if (e_ddok) cmp("model data_rdata", k, data_rdata[k], m_rdata[k]);
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic settle();
      @(negedge clock);
   endtask

   task automatic adv();
      @(posedge clock);
      #1;
   endtask

   // One complete transaction on instance k, with the slave inserting aw
   // stall cycles before address accept and ww cycles before the response.
   // cancel_ph: 0 none, 1 grant cycle, 2 first address cycle, 3 first wait cycle.
   task automatic txn(input int k, input bit is_inst, input logic [31:0] addr,
                      input bit wr, input logic [1:0] sz, input logic [31:0] wd,
                      input logic [31:0] rd, input int cancel_ph, input int aw,
                      input int ww, input bit exp_ok);
      if (is_inst) begin
         inst_req[k] = 1; inst_addr[k] = addr;
      end else begin
         data_req[k] = 1; data_addr[k] = addr; data_wr[k] = wr;
         data_size[k] = sz; data_wdata[k] = wd;
      end
      inst_cancel[k] = (cancel_ph == 1);
      settle();
      cmp("txn grant", k, is_inst ? inst_addr_ok[k] : data_addr_ok[k], 1);
      adv();
      inst_req[k] = 0; data_req[k] = 0; inst_cancel[k] = 0;
      for (int i = 0; i < aw; i++) begin
         inst_cancel[k] = (cancel_ph == 2 && i == 0);
         settle();
         cmp("txn m_addr", k, m_addr[k], addr);
         cmp("txn m_size", k, m_size[k], is_inst ? 2'd2 : sz);
         cmp("txn m_wr", k, m_wr[k], is_inst ? 1'b0 : wr);
         adv();
      end
      inst_cancel[k] = 0; m_addr_ok[k] = 1;
      settle();
      cmp("txn m_req", k, m_req[k], 1);
      adv();
      m_addr_ok[k] = 0;
      for (int i = 0; i < ww; i++) begin
         inst_cancel[k] = (cancel_ph == 3 && i == 0);
         settle();
         cmp("txn m_req wait", k, m_req[k], 0);
         adv();
      end
      inst_cancel[k] = 0; m_data_ok[k] = 1; m_rdata[k] = rd;
      settle();
      cmp("txn owner data_ok", k, is_inst ? inst_data_ok[k] : data_data_ok[k], exp_ok);
      cmp("txn other data_ok", k, is_inst ? data_data_ok[k] : inst_data_ok[k], 0);
      if (exp_ok) cmp("txn rdata", k, is_inst ? inst_rdata[k] : data_rdata[k], rd);
      adv();
      m_data_ok[k] = 0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int gq[$];
      int ng, ni, nd;
      bit pend;
      inst_req = 0; inst_cancel = 0; data_req = 0; data_wr = 0;
      m_addr_ok = 0; m_data_ok = 0;
      for (int k = 0; k < 2; k++) begin
         inst_addr[k] = 0; data_addr[k] = 0; data_wdata[k] = 0;
         m_rdata[k] = 0; data_size[k] = 0;
      end
      reset = 1;
      repeat (2) @(posedge clock);
      #1 reset = 0;

      // Reset state
      settle();
      cmp("reset m_req", 0, m_req[0], 0);
      cmp("reset m_addr", 0, m_addr[0], 0);
      cmp("reset m_size", 0, m_size[0], 0);
      cmp("reset m_wdata", 0, m_wdata[0], 0);
      cmp("reset addr_ok", 0, {inst_addr_ok[0], data_addr_ok[0]}, 0);
      adv();

      // Single fetch: grant at 0, m_req at 1, accept at 2, data at 4
      txn(0, 1, 32'hbfc00000, 0, 2'd2, 0, 32'h24010001, 0, 1, 1, 1);

      // Conflict under fixed priority: data wins, inst follows
      inst_req[0] = 1; inst_addr[0] = 32'h00001000;
      data_req[0] = 1; data_wr[0] = 1; data_size[0] = 2'd0;
      data_addr[0] = 32'h80000003; data_wdata[0] = 32'h000000ab;
      settle();
      cmp("conflict data_addr_ok", 0, data_addr_ok[0], 1);
      cmp("conflict inst_addr_ok", 0, inst_addr_ok[0], 0);
      adv();
      data_req[0] = 0; m_addr_ok[0] = 1;
      settle();
      cmp("conflict m_size", 0, m_size[0], 0);
      cmp("conflict m_wdata", 0, m_wdata[0], 32'h000000ab);
      cmp("conflict m_wr", 0, m_wr[0], 1);
      cmp("conflict m_addr", 0, m_addr[0], 32'h80000003);
      cmp("conflict inst held", 0, inst_addr_ok[0], 0);
      adv();
      m_addr_ok[0] = 0; m_data_ok[0] = 1; m_rdata[0] = 0;
      settle();
      cmp("conflict data_data_ok", 0, data_data_ok[0], 1);
      cmp("conflict no grant in done cycle", 0, inst_addr_ok[0], 0);
      adv();
      m_data_ok[0] = 0;
      settle();
      cmp("conflict inst grant", 0, inst_addr_ok[0], 1);
      adv();
      inst_req[0] = 0; m_addr_ok[0] = 1;
      settle();
      cmp("conflict inst m_addr", 0, m_addr[0], 32'h00001000);
      adv();
      m_addr_ok[0] = 0; m_data_ok[0] = 1; m_rdata[0] = 32'h5555aaaa;
      settle();
      cmp("conflict inst_data_ok", 0, inst_data_ok[0], 1);
      adv();
      m_data_ok[0] = 0;

      // Round-robin with both ports requesting continuously (instance 1)
      ng = 0; ni = 0; nd = 0; pend = 0;
      inst_addr[1] = 32'h00000100; data_addr[1] = 32'h00000200;
      data_wr[1] = 0; data_size[1] = 2'd2;
      for (int c = 0; c < 40; c++) begin
         inst_req[1] = (ng < 4); data_req[1] = (ng < 4);
         m_addr_ok[1] = m_req[1]; m_data_ok[1] = pend; m_rdata[1] = 32'h1000 + c;
         settle();
         if (data_addr_ok[1]) begin gq.push_back(0); ng++; end
         if (inst_addr_ok[1]) begin gq.push_back(1); ng++; end
         if (inst_data_ok[1]) ni++;
         if (data_data_ok[1]) nd++;
         pend = m_req[1] && m_addr_ok[1];
         if (ni + nd == 4) break;
         adv();
      end
      adv();
      inst_req[1] = 0; data_req[1] = 0; m_addr_ok[1] = 0; m_data_ok[1] = 0;
      cmp("rr grant count", 1, gq.size(), 4);
      for (int i = 0; i < gq.size() && i < 4; i++)
         cmp("rr grant order", 1, gq[i], i % 2);
      cmp("rr inst data_ok count", 1, ni, 2);
      cmp("rr data data_ok count", 1, nd, 2);

      // Cancel during wait, then a normal fetch
      txn(0, 1, 32'h00002000, 0, 2'd2, 0, 32'hcafe0001, 3, 1, 1, 0);
      txn(0, 1, 32'h00003000, 0, 2'd2, 0, 32'h11112222, 0, 1, 1, 1);
      // Cancel in the grant cycle and during the address phase
      txn(0, 1, 32'h00004000, 0, 2'd2, 0, 32'hcafe0002, 1, 1, 0, 0);
      txn(0, 1, 32'h00005000, 0, 2'd2, 0, 32'hcafe0003, 2, 2, 0, 0);
      // A data read ignores inst_cancel
      txn(0, 0, 32'h80000010, 0, 2'd1, 0, 32'h0000beef, 3, 0, 1, 1);

      // Spurious master handshakes while idle
      m_data_ok[0] = 1; m_addr_ok[0] = 1;
      settle();
      cmp("spurious inst_data_ok", 0, inst_data_ok[0], 0);
      cmp("spurious data_data_ok", 0, data_data_ok[0], 0);
      adv();
      m_data_ok[0] = 0; m_addr_ok[0] = 0;
      settle();
      cmp("spurious m_req", 0, m_req[0], 0);
      adv();

      // Reset while a write waits for its response
      data_req[0] = 1; data_wr[0] = 1; data_size[0] = 2'd2;
      data_addr[0] = 32'h80001000; data_wdata[0] = 32'hdeadbeef;
      settle();
      adv();
      data_req[0] = 0; m_addr_ok[0] = 1;
      settle();
      adv();
      m_addr_ok[0] = 0; reset = 1;
      settle();
      cmp("reset cycle data_data_ok", 0, data_data_ok[0], 0);
      adv();
      reset = 0; m_data_ok[0] = 1;
      settle();
      cmp("post-reset data_data_ok", 0, data_data_ok[0], 0);
      cmp("post-reset inst_data_ok", 0, inst_data_ok[0], 0);
      cmp("post-reset m_req", 0, m_req[0], 0);
      cmp("post-reset m_addr", 0, m_addr[0], 0);
      cmp("post-reset m_wdata", 0, m_wdata[0], 0);
      cmp("post-reset m_wr", 0, m_wr[0], 0);
      cmp("post-reset m_size", 0, m_size[0], 0);
      adv();
      m_data_ok[0] = 0; data_req[0] = 1; data_wr[0] = 0; data_addr[0] = 32'h80002000;
      settle();
      cmp("post-reset data grant", 0, data_addr_ok[0], 1);
      adv();
      data_req[0] = 0;
      settle();
      cmp("post-reset m_addr new", 0, m_addr[0], 32'h80002000);
      adv();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
Two-to-one arbiter that shares a single SRAM-like master port between the CPU instruction-fetch port and the data-memory port. It sits between the fetch/memory stages and the SRAM-like-to-AXI bridge. It keeps one transaction outstanding at a time, routes each response back to its owner, and can cancel an in-flight instruction fetch when the pipeline is flushed by a branch or exception.

Parameters:
ARB_MODE, 0, 0 = fixed priority (data wins); 1 = round-robin (the port granted last loses a tie)
RESET_LAST_INST, 1, initial "last granted" value for round-robin (1 = inst was last, so data wins the first tie)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
inst_req  in  1  fetch request, held until inst_addr_ok
inst_addr  in  32  fetch address (read only, size fixed 2'b10)
inst_cancel  in  1  pulse: discard the response of the pending or just-accepted fetch
inst_addr_ok  out  1  fetch request accepted this cycle
inst_data_ok  out  1  fetch data valid this cycle
inst_rdata  out  32  fetch data
data_req  in  1  data request, held until data_addr_ok
data_wr  in  1  1 = write
data_size  in  2  0/1/2 = byte/half/word
data_addr  in  32  data address
data_wdata  in  32  write data
data_addr_ok  out  1  data request accepted this cycle
data_data_ok  out  1  read data valid / write done
data_rdata  out  32  read data
m_req  out  1  master request
m_wr  out  1  master write
m_size  out  2  master size
m_addr  out  32  master address
m_wdata  out  32  master write data
m_addr_ok  in  1  master accepted request
m_data_ok  in  1  master response
m_rdata  in  32  master read data

Behaviour:
- FSM states: IDLE, INST_ADDR, DATA_ADDR, INST_WAIT, DATA_WAIT. Reset state is IDLE.
- IDLE:
  - If any request is present, select a winner per ARB_MODE.
  - Assert that port's addr_ok combinationally in the same cycle.
  - Latch addr, wr, size and wdata into registers. Inst latches wr = 0, size = 2, wdata = 0.
  - Go to INST_ADDR or DATA_ADDR and update last_grant. The loser sees addr_ok = 0 and keeps holding its request.
- *_ADDR: m_req = 1 and m_wr/m_size/m_addr/m_wdata are driven from the registers only. Stay in the state until m_addr_ok = 1, then go to *_WAIT. m_req is never withdrawn once raised, even when the fetch is cancelled.
- *_WAIT: m_req = 0. When m_data_ok = 1:
  - pulse the owner's data_ok in that same cycle;
  - go to IDLE. A new grant is possible only in the following cycle (minimum 1 idle cycle between transactions).
- inst_rdata and data_rdata are wired directly to m_rdata and are meaningful only while the matching data_ok is high.
- Latency: requester handshake at cycle N, m_req from N+1, data_ok in the same cycle as m_data_ok.
- Cancel (drop flag):
  - inst_cancel sets drop when it arrives in IDLE in the same cycle as an inst grant, or at any time in INST_ADDR or INST_WAIT.
  - With drop = 1, the matching m_data_ok is consumed but inst_data_ok stays 0.
  - drop clears on entry to IDLE.
  - inst_cancel in any other state, or in IDLE with no inst grant, is ignored.
  - A data transaction is never affected by inst_cancel.
- m_data_ok seen in IDLE or *_ADDR is ignored (no output pulse).
- m_addr_ok while m_req = 0 is ignored.
- Round-robin (ARB_MODE = 1): when both requests are present, grant the port not in last_grant. When only one is present, grant it.
- Reset (also mid-transaction):
  - state goes to IDLE; drop = 0; last_grant = RESET_LAST_INST ? inst : data; latched registers = 0.
  - All outputs are 0 except the rdata pass-throughs.
  - Responses still in flight from before reset are ignored by the IDLE rule.
- Exactly one of inst_addr_ok/data_addr_ok may be high in a cycle, and likewise for the two data_ok outputs.

Test Plan:
- Single fetch: inst_req with addr 0xbfc00000 at cycle 0 → inst_addr_ok at cycle 0; m_req = 1, m_addr = 0xbfc00000, m_wr = 0, m_size = 2 at cycle 1. Then m_addr_ok at cycle 2 and m_data_ok with rdata 0x24010001 at cycle 4 → inst_data_ok = 1, inst_rdata = 0x24010001 at cycle 4.
- Conflict, ARB_MODE = 0: inst_req and data_req (wr = 1, size = 0, addr 0x80000003, wdata 0xAB) together at cycle 0 → data granted first, m_size = 0 and m_wdata = 0xAB. After its data_data_ok, inst is granted in the next IDLE cycle.
- Round-robin, ARB_MODE = 1: both ports request continuously for 4 transactions → grants alternate data, inst, data, inst, and each owner's data_ok count is 2.
- Cancel: inst granted; inst_cancel pulsed during INST_WAIT; then m_data_ok → inst_data_ok stays 0, state returns to IDLE, and the next fetch completes normally.
- Spurious and reset cases: m_data_ok in IDLE → no data_ok outputs. Reset asserted during DATA_WAIT, then m_data_ok after reset deasserts → no data_data_ok, all outputs 0, and a fresh data request is granted next cycle.
